// File: rtl/apb_master_ctrl.sv
// APB master: turns one valid/ready request into an IDLE->SETUP->ACCESS transfer.
// Latency: psel 1 cycle after accept, rsp_valid 3+waits cycles after; req_ready only in IDLE.
// Optional APB_TIMEOUT_EN: aborts ACCESS after TIMEOUT_CYCLES pready-low cycles with rsp_err=1.
module apb_master_ctrl #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic              hclk,
    input  logic              hresetn,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] paddr,
    output logic              pwrite,
    output logic [DATA_W-1:0] pwdata,
    output logic              psel,
    output logic              penable,
    input  logic [DATA_W-1:0] prdata,
    input  logic              pready,
    input  logic              pslverr
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic                req_ready_q, req_ready_d;
    logic                psel_q, psel_d;
    logic                penable_q, penable_d;
    logic                pwrite_q, pwrite_d;
    logic [ADDR_W-1:0]   paddr_q, paddr_d;
    logic [DATA_W-1:0]   pwdata_q, pwdata_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic                rsp_err_q, rsp_err_d;

`ifdef APB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    logic [CNT_W-1:0]    cnt_q, cnt_d;
`endif

    always_comb begin
        state_d     = state_q;
        pwrite_d    = pwrite_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
`ifdef APB_TIMEOUT_EN
        cnt_d       = cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (req_valid && req_ready_q) begin
                    pwrite_d = req_write;
                    paddr_d  = req_addr;
                    pwdata_d = req_wdata;
                    state_d  = ST_SETUP;
                end
            end
            ST_SETUP: begin
                state_d = ST_ACCESS;
`ifdef APB_TIMEOUT_EN
                cnt_d   = '0;
`endif
            end
            ST_ACCESS: begin
                // pready wins over a coincident timeout
                if (pready) begin
                    state_d     = ST_IDLE;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = pslverr;
                    rsp_rdata_d = pwrite_q ? '0 : prdata;
                end
`ifdef APB_TIMEOUT_EN
                else if (cnt_q == CNT_LAST) begin
                    state_d     = ST_IDLE;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                    rsp_rdata_d = '0;
                    cnt_d       = cnt_q + 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            default: state_d = ST_IDLE;
        endcase
        // Bus strobes are decoded from the next state so they leave flops directly
        req_ready_d = (state_d == ST_IDLE);
        psel_d      = (state_d != ST_IDLE);
        penable_d   = (state_d == ST_ACCESS);
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            state_q     <= ST_IDLE;
            req_ready_q <= 1'b1;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
`ifdef APB_TIMEOUT_EN
            cnt_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            req_ready_q <= req_ready_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            pwrite_q    <= pwrite_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
`ifdef APB_TIMEOUT_EN
            cnt_q       <= cnt_d;
`endif
        end
    end

    assign req_ready = req_ready_q;
    assign psel      = psel_q;
    assign penable   = penable_q;
    assign pwrite    = pwrite_q;
    assign paddr     = paddr_q;
    assign pwdata    = pwdata_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_apb_master_ctrl.sv
// Directed bench for apb_master_ctrl; cycle N means N rising edges after the accepting edge.
module tb_apb_master_ctrl;

    localparam int AW = 32;
    localparam int DW = 32;

    logic          hclk = 1'b0;
    logic          hresetn;
    logic          req_valid, req_ready, req_write;
    logic [AW-1:0] req_addr, paddr;
    logic [DW-1:0] req_wdata, pwdata, rsp_rdata, prdata;
    logic          rsp_valid, rsp_err, pwrite, psel, penable, pready, pslverr;

    int n_cmp = 0;
    int n_bad = 0;

    apb_master_ctrl #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(4)) dut (
        .hclk(hclk), .hresetn(hresetn),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .paddr(paddr), .pwrite(pwrite), .pwdata(pwdata), .psel(psel), .penable(penable),
        .prdata(prdata), .pready(pready), .pslverr(pslverr)
    );

    always #5 hclk = ~hclk;

    task automatic tick();
        @(posedge hclk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic request(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = a;
        req_wdata = d;
    endtask

    initial begin
        hresetn = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
        prdata = '0; pready = 1'b0; pslverr = 1'b0;
        tick(); tick();
        check("rst_psel", psel, 0);
        check("rst_penable", penable, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_paddr", paddr, 0);
        check("rst_rsp_err", rsp_err, 0);
        hresetn = 1'b1;
        tick();
        check("post_rst_ready", req_ready, 1);

        // write, no wait states
        pready = 1'b1;
        request(1'b1, 32'h10, 32'hA5A5A5A5);
        tick();
        req_valid = 1'b0;
        check("wr_c1_psel", psel, 1);
        check("wr_c1_penable", penable, 0);
        check("wr_c1_ready", req_ready, 0);
        check("wr_c1_paddr", paddr, 32'h10);
        check("wr_c1_pwrite", pwrite, 1);
        check("wr_c1_pwdata", pwdata, 32'hA5A5A5A5);
        tick();
        check("wr_c2_penable", penable, 1);
        check("wr_c2_rsp_valid", rsp_valid, 0);
        tick();
        check("wr_c3_rsp_valid", rsp_valid, 1);
        check("wr_c3_rsp_err", rsp_err, 0);
        check("wr_c3_rsp_rdata", rsp_rdata, 0);
        check("wr_c3_psel", psel, 0);
        check("wr_c3_ready", req_ready, 1);
        tick();
        check("wr_c4_rsp_valid", rsp_valid, 0);
        check("wr_c4_paddr_hold", paddr, 32'h10);

        // read with two wait states; off-edge prdata must be ignored
        pready = 1'b0; prdata = 32'h33;
        request(1'b0, 32'h24, 32'h0);
        tick();
        req_valid = 1'b0;
        check("rd_c1_penable", penable, 0);
        tick();
        check("rd_c2_penable", penable, 1);
        check("rd_c2_paddr", paddr, 32'h24);
        tick();
        check("rd_c3_rsp_valid", rsp_valid, 0);
        check("rd_c3_paddr", paddr, 32'h24);
        tick();
        check("rd_c4_rsp_valid", rsp_valid, 0);
        check("rd_c4_paddr", paddr, 32'h24);
        check("rd_c4_penable", penable, 1);
        pready = 1'b1; prdata = 32'h5A;
        tick();
        check("rd_c5_rsp_valid", rsp_valid, 1);
        check("rd_c5_rsp_rdata", rsp_rdata, 32'h5A);
        check("rd_c5_rsp_err", rsp_err, 0);

        // slave error on read
        pslverr = 1'b1; prdata = 32'hDEAD;
        request(1'b0, 32'h30, 32'h0);
        tick();
        req_valid = 1'b0;
        tick();
        tick();
        check("err_c3_rsp_valid", rsp_valid, 1);
        check("err_c3_rsp_err", rsp_err, 1);
        check("err_c3_rsp_rdata", rsp_rdata, 32'hDEAD);
        pslverr = 1'b0; prdata = 32'h0;
        tick();
        check("err_c4_err_hold", rsp_err, 1);
        check("err_c4_rdata_hold", rsp_rdata, 32'hDEAD);
        check("err_c4_rsp_valid", rsp_valid, 0);

        // back-to-back with req_valid held high
        request(1'b1, 32'h40, 32'h1111);
        tick();
        check("b2b_c1_psel", psel, 1);
        check("b2b_c1_ready", req_ready, 0);
        req_addr = 32'h44; req_wdata = 32'h2222;
        tick();
        check("b2b_c2_ready", req_ready, 0);
        check("b2b_c2_paddr", paddr, 32'h40);
        tick();
        check("b2b_c3_rsp_valid", rsp_valid, 1);
        check("b2b_c3_psel", psel, 0);
        check("b2b_c3_ready", req_ready, 1);
        tick();
        req_valid = 1'b0;
        check("b2b_c4_psel", psel, 1);
        check("b2b_c4_penable", penable, 0);
        check("b2b_c4_paddr", paddr, 32'h44);
        check("b2b_c4_pwdata", pwdata, 32'h2222);
        tick();
        tick();
        check("b2b_c6_rsp_valid", rsp_valid, 1);

        // reset in the middle of ACCESS
        pready = 1'b0;
        request(1'b0, 32'h50, 32'h0);
        tick();
        req_valid = 1'b0;
        tick();
        check("rma_c2_penable", penable, 1);
        #2 hresetn = 1'b0;
        #1;
        check("rma_async_psel", psel, 0);
        check("rma_async_penable", penable, 0);
        check("rma_async_paddr", paddr, 0);
        pready = 1'b1;
        tick();
        check("rma_rsp_valid", rsp_valid, 0);
        hresetn = 1'b1;
        pready = 1'b0;
        tick();
        check("rma_ready", req_ready, 1);
        check("rma_no_rsp", rsp_valid, 0);
        check("rma_psel", psel, 0);

        // pready stuck low
        prdata = 32'h77;
        request(1'b0, 32'h60, 32'h0);
        tick();
        req_valid = 1'b0;
        for (int c = 2; c <= 5; c++) begin
            tick();
            check($sformatf("to_c%0d_penable", c), penable, 1);
            check($sformatf("to_c%0d_rsp_valid", c), rsp_valid, 0);
        end
        tick();
`ifdef APB_TIMEOUT_EN
        check("to_c6_rsp_valid", rsp_valid, 1);
        check("to_c6_rsp_err", rsp_err, 1);
        check("to_c6_rsp_rdata", rsp_rdata, 0);
        check("to_c6_psel", psel, 0);
`else
        check("to_c6_psel", psel, 1);
        check("to_c6_penable", penable, 1);
        check("to_c6_rsp_valid", rsp_valid, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
